// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// fetch_stage_pkg : shared pipeline types and instruction field layout
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 12;
  localparam int OP1_LSB = 8;
  localparam int OP2_LSB = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'hF000;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : pipeline buffer with flush (bubble) > hold > load priority
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_reg #(
  parameter int               DATA_W = 16,
  parameter int               PC_W   = 8,
  parameter logic [DATA_W-1:0] NOP   = 16'hF000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [PC_W-1:0]   i_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_instr;
  logic [PC_W-1:0]   r_pc;
  logic              r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : IF stage with BOOT/RUN/TRAP control, PC and IF/ID buffer.
// Optional stall counter enabled by FETCH_STALL_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                 PC_W      = 8,
  parameter logic [PC_W-1:0]    RESET_PC  = 'h00,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pcCtrl,
  input  logic               bufferCtrl,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               opCode_error,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [PC_W-1:0]    IF_ID_pc,
  output logic               IF_ID_valid,
  output logic [FIELD_W-1:0] IF_ID_opCode,
  output logic [FIELD_W-1:0] IF_ID_Op1,
  output logic [FIELD_W-1:0] IF_ID_Op2,
  output logic               trap
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]        stall_count
`endif
);

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            w_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (opCode_error && IF_ID_valid) w_state_nxt = ST_TRAP;
        // Flush outranks the hazard stall.
        if (branch_taken)   w_pc_nxt = branch_target;
        else if (pcCtrl)    w_pc_nxt = r_pc + PC_W'(1);
      end
      default: ;
    endcase
  end

  // Outside RUN the buffer is pinned to a bubble regardless of inputs.
  assign w_flush = (r_state != ST_RUN) || branch_taken;

  if_id_reg #(
    .DATA_W (INSTR_W),
    .PC_W   (PC_W),
    .NOP    (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_load  (bufferCtrl),
    .i_instr (imem_data),
    .i_pc    (r_pc),
    .o_instr (IF_ID_instr),
    .o_pc    (IF_ID_pc),
    .o_valid (IF_ID_valid)
  );

  assign imem_addr    = r_pc;
  assign trap         = (r_state == ST_TRAP);
  assign IF_ID_opCode = IF_ID_instr[OPC_LSB +: FIELD_W];
  assign IF_ID_Op1    = IF_ID_instr[OP1_LSB +: FIELD_W];
  assign IF_ID_Op2    = IF_ID_instr[OP2_LSB +: FIELD_W];

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && !pcCtrl && !branch_taken &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : table-driven directed checks for fetch_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcCtrl = 1'b1;
  logic        bufferCtrl = 1'b1;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        opCode_error = 1'b0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] IF_ID_instr;
  logic [7:0]  IF_ID_pc;
  logic        IF_ID_valid;
  logic [3:0]  IF_ID_opCode, IF_ID_Op1, IF_ID_Op2;
  logic        trap;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: imem[i] = 16'h1000 + i
  assign imem_data = 16'h1000 + {8'h00, imem_addr};

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pcCtrl        (pcCtrl),
    .bufferCtrl    (bufferCtrl),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .opCode_error  (opCode_error),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_valid   (IF_ID_valid),
    .IF_ID_opCode  (IF_ID_opCode),
    .IF_ID_Op1     (IF_ID_Op1),
    .IF_ID_Op2     (IF_ID_Op2),
    .trap          (trap)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  typedef struct {
    logic        pc_ctrl;
    logic        buf_ctrl;
    logic        br;
    logic [7:0]  tgt;
    logic        err;
    logic [7:0]  e_addr;
    logic [15:0] e_instr;
    logic [7:0]  e_pc;
    logic        e_valid;
    logic        e_trap;
    logic [15:0] e_stall;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [7:0] a, input logic [15:0] ins,
                             input logic [7:0] p, input logic v, input logic t);
    chk({tag, ".addr"},  {24'h0, imem_addr}, {24'h0, a});
    chk({tag, ".instr"}, {16'h0, IF_ID_instr}, {16'h0, ins});
    chk({tag, ".pc"},    {24'h0, IF_ID_pc}, {24'h0, p});
    chk({tag, ".valid"}, {31'h0, IF_ID_valid}, {31'h0, v});
    chk({tag, ".trap"},  {31'h0, trap}, {31'h0, t});
    chk({tag, ".fields"}, {20'h0, IF_ID_opCode, IF_ID_Op1, IF_ID_Op2}, {20'h0, ins[15:4]});
  endtask

  initial begin
    //          pc buf br tgt   err  addr   instr     pc    v  t  stall
    vecs[0]  = '{1, 1, 0, 8'h00, 0, 8'h00, 16'hF000, 8'h00, 0, 0, 16'd0}; // BOOT
    vecs[1]  = '{1, 1, 0, 8'h00, 0, 8'h01, 16'h1000, 8'h00, 1, 0, 16'd0};
    vecs[2]  = '{1, 1, 0, 8'h00, 0, 8'h02, 16'h1001, 8'h01, 1, 0, 16'd0};
    vecs[3]  = '{1, 1, 0, 8'h00, 0, 8'h03, 16'h1002, 8'h02, 1, 0, 16'd0};
    vecs[4]  = '{1, 1, 0, 8'h00, 0, 8'h04, 16'h1003, 8'h03, 1, 0, 16'd0};
    vecs[5]  = '{0, 0, 0, 8'h00, 0, 8'h04, 16'h1003, 8'h03, 1, 0, 16'd1}; // stall
    vecs[6]  = '{0, 0, 0, 8'h00, 0, 8'h04, 16'h1003, 8'h03, 1, 0, 16'd2};
    vecs[7]  = '{1, 1, 0, 8'h00, 0, 8'h05, 16'h1004, 8'h04, 1, 0, 16'd2};
    vecs[8]  = '{0, 1, 1, 8'h40, 0, 8'h40, 16'hF000, 8'h00, 0, 0, 16'd2}; // flush beats stall
    vecs[9]  = '{1, 1, 0, 8'h00, 0, 8'h41, 16'h1040, 8'h40, 1, 0, 16'd2};
    vecs[10] = '{1, 0, 1, 8'hFE, 0, 8'hFE, 16'hF000, 8'h00, 0, 0, 16'd2};
    vecs[11] = '{1, 1, 0, 8'h00, 0, 8'hFF, 16'h10FE, 8'hFE, 1, 0, 16'd2};
    vecs[12] = '{1, 1, 0, 8'h00, 0, 8'h00, 16'h10FF, 8'hFF, 1, 0, 16'd2}; // wrap
    vecs[13] = '{1, 1, 0, 8'h00, 0, 8'h01, 16'h1000, 8'h00, 1, 0, 16'd2};
    vecs[14] = '{1, 0, 0, 8'h00, 0, 8'h02, 16'h1000, 8'h00, 1, 0, 16'd2}; // buffer hold only
    vecs[15] = '{0, 1, 0, 8'h00, 0, 8'h02, 16'h1002, 8'h02, 1, 0, 16'd3}; // PC hold only
    vecs[16] = '{1, 1, 1, 8'h10, 0, 8'h10, 16'hF000, 8'h00, 0, 0, 16'd3};
    vecs[17] = '{1, 1, 0, 8'h00, 1, 8'h11, 16'h1010, 8'h10, 1, 0, 16'd3}; // error on bubble
    vecs[18] = '{1, 1, 0, 8'h00, 1, 8'h12, 16'h1011, 8'h11, 1, 1, 16'd3}; // -> TRAP
    vecs[19] = '{0, 1, 1, 8'h33, 0, 8'h12, 16'hF000, 8'h00, 0, 1, 16'd3};
    vecs[20] = '{1, 1, 0, 8'h00, 0, 8'h12, 16'hF000, 8'h00, 0, 1, 16'd3};

    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 8'h00, 16'hF000, 8'h00, 1'b0, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    chk("reset.stall", {16'h0, stall_count}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      pcCtrl        = vecs[i].pc_ctrl;
      bufferCtrl    = vecs[i].buf_ctrl;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      opCode_error  = vecs[i].err;
      @(posedge clk);
      #1;
      chk_outputs($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_instr,
                  vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_trap);
`ifdef FETCH_STALL_CNT_EN
      chk($sformatf("v%0d.stall", i), {16'h0, stall_count}, {16'h0, vecs[i].e_stall});
`endif
    end

    // Asynchronous reset out of TRAP, mid-cycle, then a fresh boot.
    pcCtrl = 1'b1; bufferCtrl = 1'b1; branch_taken = 1'b0; opCode_error = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs("async_rst", 8'h00, 16'hF000, 8'h00, 1'b0, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    chk("async_rst.stall", {16'h0, stall_count}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs("reboot", 8'h00, 16'hF000, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_outputs("refetch", 8'h01, 16'h1000, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
